apb_master_arb: RTL and testbench



---
 rtl/apb_master_arb.sv | 142 ++++++++++++++
 tb/tb_apb_master_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// apb_master_arb: shares one APB master among NUM_REQ requesters with round-robin grants.
// Optional wait-state timeout is compiled in with `define APB_MASTER_ARB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int NUM_REQ            = 2,
  parameter int APB_MAX_DATA_WIDTH = 32,
  parameter int APB_MAX_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                                  pclk,
  input  logic                                  preset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*APB_MAX_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*APB_MAX_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [APB_MAX_DATA_WIDTH-1:0]         rsp_rdata,
  output logic                                  rsp_slverr,
  output logic [APB_MAX_ADDR_WIDTH-1:0]         paddr,
  output logic                                  pwrite,
  output logic                                  psel,
  output logic                                  penable,
  output logic [APB_MAX_DATA_WIDTH-1:0]         pwdata,
  input  logic                                  pready,
  input  logic [APB_MAX_DATA_WIDTH-1:0]         prdata,
  input  logic                                  pslverr,
  output logic [1:0]                            dbg_state
);
  localparam int AW = APB_MAX_ADDR_WIDTH;
  localparam int DW = APB_MAX_DATA_WIDTH;
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a request transfers on the edge where req_valid[i] && req_ready[i];
  // req_ready is only offered in IDLE, and rsp_valid is a single-cycle pulse.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2} state_t;

  state_t        state, state_nx;
  logic [LW-1:0] last, winner, cand;
  logic          found, grant, complete, timed_out;
  int            idx;

  assign dbg_state = state;

`ifdef APB_MASTER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge pclk) begin
    if (preset || state == S_SETUP) begin
      tmo_cnt <= '0;
    end else if (state == S_ACCESS && !pready) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last) + k) % NUM_REQ;
      cand = LW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    grant     = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (found && !preset) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_nx          = S_SETUP;
        end
      end
      S_SETUP: state_nx = S_ACCESS;
      S_ACCESS: begin
        if (pready) begin
          complete = 1'b1;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          complete  = 1'b1;
          timed_out = 1'b1;
`endif
        end
        if (complete) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= S_IDLE;
      last       <= LW'(NUM_REQ - 1);
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      state      <= state_nx;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      if (grant) begin
        paddr   <= req_addr[int'(winner)*AW +: AW];
        pwrite  <= req_write[winner];
        pwdata  <= req_write[winner] ? req_wdata[int'(winner)*DW +: DW] : '0;
        psel    <= 1'b1;
        penable <= 1'b0;
        last    <= winner;
      end
      if (state == S_SETUP) penable <= 1'b1;
      // last still names the owner here; it only moves on the next grant.
      if (complete) begin
        psel            <= 1'b0;
        penable         <= 1'b0;
        rsp_valid[last] <= 1'b1;
        rsp_rdata       <= (pwrite || timed_out) ? '0 : prdata;
        rsp_slverr      <= pslverr | timed_out;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed scenarios plus a randomized
// run checked against a timeline model of grants, APB phases and responses.
module tb_apb_master_arb;
  localparam int NR = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic           pclk = 1'b0;
  logic           preset;
  logic [NR-1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]  rsp_rdata, pwdata, prdata;
  logic           rsp_slverr, pwrite, psel, penable, pready, pslverr;
  logic [AW-1:0]  paddr;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_arb #(
    .NUM_REQ(NR), .APB_MAX_DATA_WIDTH(DW), .APB_MAX_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .dbg_state(dbg_state)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    preset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    tick(); tick();
    n_checks++; if ({psel, penable, pwrite, rsp_slverr} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {psel, penable, pwrite, rsp_slverr}); end
    n_checks++; if (paddr !== '0) begin n_fail++; $display("FAIL reset_paddr: got %h want 0", paddr); end
    n_checks++; if (pwdata !== '0) begin n_fail++; $display("FAIL reset_pwdata: got %h want 0", pwdata); end
    n_checks++; if (rsp_valid !== '0 || rsp_rdata !== '0) begin n_fail++; $display("FAIL reset_rsp: got %b/%h want 0/0", rsp_valid, rsp_rdata); end
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    preset = 1'b0;
    req_valid = '1;
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_prio: got %b want 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'hCAFE_F00D;
    set_req(0, 1'b1, 1'b1, 16'h0004, 32'hDEAD_BEEF);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL wr_grant: got %b want 001", req_ready); end
    tick(); req_valid = '0;
    n_checks++; if ({psel, penable} !== 2'b10) begin n_fail++; $display("FAIL wr_setup: psel/penable got %b want 10", {psel, penable}); end
    n_checks++; if (paddr !== 16'h0004 || pwrite !== 1'b1 || pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_fields: got %h/%b/%h want 0004/1/deadbeef", paddr, pwrite, pwdata); end
    tick();
    n_checks++; if ({psel, penable} !== 2'b11 || rsp_valid !== '0) begin n_fail++; $display("FAIL wr_access: got %b rsp %b want 11 rsp 000", {psel, penable}, rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 3'b001 || rsp_slverr !== 1'b0 || rsp_rdata !== '0) begin n_fail++; $display("FAIL wr_rsp: got %b/%b/%h want 001/0/0", rsp_valid, rsp_slverr, rsp_rdata); end
    n_checks++; if ({psel, penable} !== 2'b00 || paddr !== 16'h0004) begin n_fail++; $display("FAIL wr_end: got %b paddr %h want 00 paddr 0004", {psel, penable}, paddr); end
    tick();
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL wr_pulse: got %b want 000", rsp_valid); end
  endtask

  task automatic test_read_wait();
    pready = 1'b0; prdata = '0;
    set_req(1, 1'b1, 1'b0, 16'h0100, 32'h5555_5555);
    #1;
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rd_grant: got %b want 010", req_ready); end
    tick(); req_valid = '0;
    n_checks++; if ({psel, penable, pwrite} !== 3'b100 || pwdata !== '0 || paddr !== 16'h0100) begin n_fail++; $display("FAIL rd_setup: got %b/%h/%h want 100/0/0100", {psel, penable, pwrite}, pwdata, paddr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if ({psel, penable} !== 2'b11 || paddr !== 16'h0100 || rsp_valid !== '0) begin n_fail++; $display("FAIL rd_wait%0d: got %b/%h/%b want 11/0100/000", k, {psel, penable}, paddr, rsp_valid); end
      if (k == 2) begin pready = 1'b1; prdata = 32'h1234_5678; end
    end
    tick();
    pready = 1'b0;
    n_checks++; if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h1234_5678 || rsp_slverr !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got %b/%h/%b want 010/12345678/0", rsp_valid, rsp_rdata, rsp_slverr); end
    n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL rd_end: got %b want 00", {psel, penable}); end
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int low_run = 0;
    bit seen_high = 1'b0;
    logic [NR-1:0] exp;
    pready = 1'b1; pslverr = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0010, 32'h1000_0000);
    set_req(1, 1'b1, 1'b1, 16'h0020, 32'h2000_0000);
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      if (req_ready !== '0) begin
        exp = (grants % 2 == 0) ? 3'b001 : 3'b010;
        n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", grants, req_ready, exp); end
        grants++;
      end
      tick();
      if (psel) begin
        if (seen_high && low_run > 0) begin
          n_checks++; if (low_run != 1) begin n_fail++; $display("FAIL rr_gap: psel low %0d cycles want 1", low_run); end
        end
        seen_high = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
    req_valid = '0;
    n_checks++; if (grants != 4) begin n_fail++; $display("FAIL rr_count: got %0d grants want 4", grants); end
    tick(); tick(); tick();
  endtask

  task automatic test_slave_error();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5_A5A5;
    set_req(0, 1'b1, 1'b1, 16'h0030, 32'h0BAD_0BAD);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL err_grant: got %b want 001", req_ready); end
    tick(); req_valid = '0; tick(); tick();
    n_checks++; if (rsp_valid !== 3'b001 || rsp_slverr !== 1'b1 || rsp_rdata !== '0) begin n_fail++; $display("FAIL err_wr_rsp: got %b/%b/%h want 001/1/0", rsp_valid, rsp_slverr, rsp_rdata); end
    set_req(1, 1'b1, 1'b0, 16'h0034, 32'h0);
    #1;
    tick(); req_valid = '0; tick(); tick();
    n_checks++; if (rsp_valid !== 3'b010 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL err_rd_rsp: got %b/%b/%h want 010/1/a5a5a5a5", rsp_valid, rsp_slverr, rsp_rdata); end
    pslverr = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    pready = 1'b0; pslverr = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0040, 32'h0);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_grant: got %b want 001", req_ready); end
    tick(); req_valid = '0; tick();
    n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL rst_access: got %b want 11", {psel, penable}); end
    preset = 1'b1;
    tick();
    preset = 1'b0;
    n_checks++; if ({psel, penable} !== 2'b00 || rsp_valid !== '0) begin n_fail++; $display("FAIL rst_drop: got %b rsp %b want 00 rsp 000", {psel, penable}, rsp_valid); end
    pready = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== '0 || psel !== 1'b0) begin n_fail++; $display("FAIL rst_norsp: got rsp %b psel %b want 000/0", rsp_valid, psel); end
    pready = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0050, 32'h0);
    set_req(1, 1'b1, 1'b1, 16'h0060, 32'h0);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rst_ptr: got %b want 001", req_ready); end
    req_valid = '0;
  endtask

`ifdef APB_MASTER_ARB_TIMEOUT_EN
  task automatic test_timeout();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFF_FFFF;
    set_req(0, 1'b1, 1'b0, 16'h0070, 32'h0);
    #1;
    for (int age = 1; age <= 7; age++) begin
      tick();
      req_valid = '0;
      if (age == 6) begin
        n_checks++; if (rsp_valid !== 3'b001 || rsp_slverr !== 1'b1 || rsp_rdata !== '0) begin n_fail++; $display("FAIL tmo_rsp: got %b/%b/%h want 001/1/0", rsp_valid, rsp_slverr, rsp_rdata); end
      end else begin
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL tmo_early%0d: got %b want 000", age, rsp_valid); end
      end
    end
  endtask
`endif

  // Model: a grant at cycle n gives SETUP at n+1, ACCESS n+2..n+2+w, response at n+3+w.
  task automatic test_random();
    bit busy = 1'b0;
    bit have_cur = 1'b0;
    int age = 0, w = 0, owner = 0, m_last = NR - 1, drop = -1, win;
    logic [AW-1:0] c_addr = '0;
    logic          c_write = 1'b0;
    logic [DW-1:0] c_wdata = '0, e_rd = '0;
    logic          e_err = 1'b0, e_psel, e_pen;
    logic [NR-1:0] e_ready, e_rsp;
    preset = 1'b1; req_valid = '0; pready = 1'b0;
    tick();
    preset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (busy) age++;
      e_psel = busy && age >= 1 && age <= 2 + w;
      e_pen  = busy && age >= 2 && age <= 2 + w;
      e_rsp  = (busy && age == 3 + w) ? (NR'(1) << owner) : '0;
      n_checks++; if (psel !== e_psel || penable !== e_pen) begin n_fail++; $display("FAIL rnd_phase c%0d: got %b%b want %b%b", c, psel, penable, e_psel, e_pen); end
      n_checks++; if (rsp_valid !== e_rsp) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid, e_rsp); end
      if (e_rsp != '0) begin
        n_checks++; if (rsp_rdata !== e_rd || rsp_slverr !== e_err) begin n_fail++; $display("FAIL rnd_rsp_data c%0d: got %h/%b want %h/%b", c, rsp_rdata, rsp_slverr, e_rd, e_err); end
        busy = 1'b0;
      end
      if (have_cur) begin
        n_checks++; if (paddr !== c_addr || pwrite !== c_write || pwdata !== (c_write ? c_wdata : '0)) begin n_fail++; $display("FAIL rnd_fields c%0d: got %h/%b/%h want %h/%b/%h", c, paddr, pwrite, pwdata, c_addr, c_write, c_write ? c_wdata : '0); end
      end
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
      if (busy && age == 2 + w) begin
        pready = 1'b1;
        e_rd   = c_write ? '0 : prdata;
        e_err  = pslverr;
      end else if (busy && age >= 2) begin
        pready = 1'b0;
      end else begin
        pready = 1'($urandom_range(0, 1));
      end
      if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      #1;
      e_ready = '0;
      win = -1;
      if (!busy) begin
        for (int k = 1; k <= NR; k++) begin
          if (win < 0 && req_valid[(m_last + k) % NR]) win = (m_last + k) % NR;
        end
      end
      if (win >= 0) e_ready[win] = 1'b1;
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b want %b", c, req_ready, e_ready); end
      if (win >= 0) begin
        busy = 1'b1; age = 0; w = $urandom_range(0, 3); owner = win; m_last = win;
        c_addr = req_addr[win*AW +: AW]; c_write = req_write[win]; c_wdata = req_wdata[win*DW +: DW];
        have_cur = 1'b1;
        drop = win;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_slave_error();
    test_reset_mid();
`ifdef APB_MASTER_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
